fifo_rd_rr_scheduler: RTL and testbench

//  Read-side scheduler for NUM_CH dual-clock Gray-pointer FIFOs that share the clk_rd domain.

---
 rtl/fifo_rd_rr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fifo_rd_rr_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_rr_scheduler.sv
// Round-robin read scheduler for NUM_CH clk_rd-domain FIFOs. It drains each granted FIFO in bursts
// of up to BURST_MAX words and merges all channels into one valid/ready stream tagged with the channel.
module fifo_rd_rr_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                       clk_rd,
    input  logic                       rd_reset,
    input  logic [NUM_CH-1:0]          fifo_empty,
    input  logic [NUM_CH*DATA_W-1:0]   fifo_dout,
    output logic [NUM_CH-1:0]          fifo_rd_en,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [CH_W-1:0]            m_chan,
    output logic                       busy
);

    localparam int              BC_W       = $clog2(BURST_MAX + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);
    localparam logic [CH_W:0]   NUM_CH_X   = (CH_W + 1)'(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t            r_state, w_state_next;
    logic [CH_W-1:0]   r_grant_ch, w_grant_ch_next;
    logic [CH_W-1:0]   r_last_grant, w_last_grant_next;
    logic [BC_W-1:0]   r_burst_cnt, w_burst_cnt_next;

    logic              r_inflight;
    logic [CH_W-1:0]   r_inflight_ch;

    logic [DATA_W-1:0] r_obuf_data [2];
    logic [CH_W-1:0]   r_obuf_chan [2];
    logic              r_obuf_wptr;
    logic              r_obuf_rptr;
    logic [1:0]        r_obuf_occ;

    logic [DATA_W-1:0] w_dout     [NUM_CH];
    logic [CH_W:0]     w_cand_sum [NUM_CH];
    logic [CH_W-1:0]   w_cand     [NUM_CH];
    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    logic              w_pop;
    logic [2:0]        w_credit_sum;
    logic              w_credit_ok;
    logic              w_issue;

    // Candidate k is the (k+1)-th channel after the last grant, wrapped modulo NUM_CH
    // without relying on NUM_CH being a power of two.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign w_dout[gi]     = fifo_dout[gi*DATA_W +: DATA_W];
        assign w_cand_sum[gi] = {1'b0, r_last_grant} + (CH_W + 1)'(gi + 1);
        assign w_cand[gi]     = (w_cand_sum[gi] >= NUM_CH_X) ? CH_W'(w_cand_sum[gi] - NUM_CH_X)
                                                             : w_cand_sum[gi][CH_W-1:0];
        assign fifo_rd_en[gi] = w_issue && (r_grant_ch == CH_W'(gi));
    end

    // Walk from the farthest candidate to the nearest so the nearest non-empty channel wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!fifo_empty[w_cand[k]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[k];
            end
        end
    end

    // A new read lands in the buffer two edges from now; it fits only if fewer than two
    // words remain after this edge's capture and pop.
    assign w_pop        = m_valid && m_ready;
    assign w_credit_sum = {1'b0, r_obuf_occ} + {2'b00, r_inflight};
    assign w_credit_ok  = (w_credit_sum - {2'b00, w_pop}) < 3'd2;
    assign w_issue      = (r_state == ST_GRANT) && w_credit_ok && !fifo_empty[r_grant_ch];

    always_comb begin
        w_state_next      = r_state;
        w_grant_ch_next   = r_grant_ch;
        w_last_grant_next = r_last_grant;
        w_burst_cnt_next  = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next      = ST_GRANT;
                    w_grant_ch_next   = w_pick;
                    w_last_grant_next = w_pick;
                    w_burst_cnt_next  = '0;
                end
            end
            ST_GRANT: begin
                if (w_credit_ok) begin
                    if (fifo_empty[r_grant_ch]) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_burst_cnt_next = r_burst_cnt + 1'b1;
                        if (r_burst_cnt == BURST_LAST) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rd or posedge rd_reset) begin
        if (rd_reset) begin
            r_state       <= ST_IDLE;
            r_grant_ch    <= '0;
            r_last_grant  <= CH_W'(NUM_CH - 1);
            r_burst_cnt   <= '0;
            r_inflight    <= 1'b0;
            r_inflight_ch <= '0;
        end else begin
            r_state       <= w_state_next;
            r_grant_ch    <= w_grant_ch_next;
            r_last_grant  <= w_last_grant_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_inflight    <= w_issue;
            r_inflight_ch <= r_grant_ch;
        end
    end

    // Two-entry output buffer; a capture and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk_rd or posedge rd_reset) begin
        if (rd_reset) begin
            for (int e = 0; e < 2; e++) begin
                r_obuf_data[e] <= '0;
                r_obuf_chan[e] <= '0;
            end
            r_obuf_wptr <= 1'b0;
            r_obuf_rptr <= 1'b0;
            r_obuf_occ  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_obuf_data[r_obuf_wptr] <= w_dout[r_inflight_ch];
                r_obuf_chan[r_obuf_wptr] <= r_inflight_ch;
                r_obuf_wptr              <= ~r_obuf_wptr;
            end
            if (w_pop) begin
                r_obuf_rptr <= ~r_obuf_rptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_obuf_occ <= r_obuf_occ + 2'd1;
                2'b01:   r_obuf_occ <= r_obuf_occ - 2'd1;
                default: r_obuf_occ <= r_obuf_occ;
            endcase
        end
    end

    assign m_valid = (r_obuf_occ != 2'd0);
    assign m_data  = r_obuf_data[r_obuf_rptr];
    assign m_chan  = r_obuf_chan[r_obuf_rptr];
    assign busy    = (r_state != ST_IDLE) || r_inflight || (r_obuf_occ != 2'd0);

endmodule

// File: tb/tb_fifo_rd_rr_scheduler.sv
// Bench for fifo_rd_rr_scheduler: behavioural read-side FIFOs, per-channel scoreboard queues
// and scenario tasks for reset, round-robin bursts, back-pressure, random traffic and mid-burst reset.
module tb_fifo_rd_rr_scheduler;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;
    localparam int CH_W      = 2;

    logic                     clk_rd = 1'b0;
    logic                     rd_reset;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH*DATA_W-1:0] fifo_dout;
    logic [NUM_CH-1:0]        fifo_rd_en;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [CH_W-1:0]          m_chan;
    logic                     busy;

    fifo_rd_rr_scheduler #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX),
        .CH_W      (CH_W)
    ) dut (
        .clk_rd     (clk_rd),
        .rd_reset   (rd_reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .busy       (busy)
    );

    always #5 clk_rd = ~clk_rd;

    // Read side of each FIFO: combinational empty, data registered one cycle after rd_en.
    logic [7:0] mem [NUM_CH][256];
    int         wr_ptr [NUM_CH];
    int         rd_ptr [NUM_CH];
    logic [7:0] dout_reg [NUM_CH];

    always @(posedge clk_rd or posedge rd_reset) begin
        if (rd_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c]   <= wr_ptr[c];
                dout_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fifo_rd_en[c] && (rd_ptr[c] != wr_ptr[c])) begin
                    dout_reg[c] <= mem[c][rd_ptr[c][7:0]];
                    rd_ptr[c]   <= rd_ptr[c] + 1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        assign fifo_empty[g]          = (rd_ptr[g] == wr_ptr[g]);
        assign fifo_dout[g*8 +: 8]    = dout_reg[g];
    end

    // Scoreboard and monitor state
    logic [7:0] exp_q [NUM_CH][$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         n_pop   = 0;
    int         out_cnt = 0;
    bit         mon_en  = 1'b0;
    logic [7:0] mon_exp;
    logic [3:0] prev_en = 4'b0;
    int         cur_len = 0;
    logic [3:0] bl_en  [$];
    int         bl_len [$];

    task automatic push(input int ch, input logic [7:0] d);
        mem[ch][wr_ptr[ch][7:0]] = d;
        wr_ptr[ch] = wr_ptr[ch] + 1;
        exp_q[ch].push_back(d);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_rd);
            if (!busy && (fifo_empty == 4'hF)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int pending_words();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += exp_q[c].size();
        return s;
    endfunction

    always @(negedge clk_rd) begin
        if (mon_en) begin
            n_cmp++;
            if ((fifo_rd_en & fifo_empty) != 4'b0) begin
                n_err++;
                $display("FAIL rd_en_on_empty: rd_en=%b empty=%b, required no overlap", fifo_rd_en, fifo_empty);
            end
            n_cmp++;
            if ($countones(fifo_rd_en) > 1) begin
                n_err++;
                $display("FAIL rd_en_onehot: rd_en=%b, required at most one bit", fifo_rd_en);
            end
            n_cmp++;
            if (out_cnt > 2) begin
                n_err++;
                $display("FAIL obuf_occupancy: held=%0d, required <= 2", out_cnt);
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (exp_q[m_chan].size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: ch=%0d data=%h, required no word", m_chan, m_data);
                end else begin
                    mon_exp = exp_q[m_chan].pop_front();
                    if (m_data !== mon_exp) begin
                        n_err++;
                        $display("FAIL word_order: ch=%0d data=%h, required %h", m_chan, m_data, mon_exp);
                    end
                end
                n_pop++;
                $display("word ch=%0d data=%h", m_chan, m_data);
            end
            out_cnt = out_cnt + ((fifo_rd_en != 4'b0) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (fifo_rd_en != 4'b0) begin
                if (fifo_rd_en == prev_en) begin
                    cur_len++;
                end else begin
                    if (cur_len > 0) begin
                        bl_en.push_back(prev_en);
                        bl_len.push_back(cur_len);
                    end
                    cur_len = 1;
                end
            end else if (cur_len > 0) begin
                bl_en.push_back(prev_en);
                bl_len.push_back(cur_len);
                cur_len = 0;
            end
            prev_en = fifo_rd_en;
        end
    end

    task automatic test_reset();
        rd_reset = 1'b0;
        m_ready  = 1'b0;
        #2 rd_reset = 1'b1;
        @(negedge clk_rd);
        n_cmp++;
        if (fifo_rd_en !== 4'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 8'h00 || m_chan !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: rd_en=%b valid=%b busy=%b data=%h chan=%0d, required all 0",
                     fifo_rd_en, m_valid, busy, m_data, m_chan);
        end
        @(posedge clk_rd); #1;
        rd_reset = 1'b0;
        mon_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_rd);
            n_cmp++;
            if (fifo_rd_en !== 4'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_reset: cyc=%0d rd_en=%b valid=%b busy=%b, required 0/0/0",
                         i, fifo_rd_en, m_valid, busy);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        bit         ok;
        int         pop0;
        logic [3:0] e_en;
        int         e_len;
        @(posedge clk_rd); #1;
        m_ready = 1'b1;
        bl_en.delete();
        bl_len.delete();
        pop0 = n_pop;
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 6; w++) push(c, 8'(c*16 + w));
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rr_drain: timed out, required drain in 300 cycles"); end
        n_cmp++;
        if (bl_en.size() != 8) begin
            n_err++;
            $display("FAIL rr_burst_count: bursts=%0d, required 8", bl_en.size());
        end
        for (int i = 0; i < 8 && i < bl_en.size(); i++) begin
            e_en  = 4'b0001 << (i % 4);
            e_len = (i < 4) ? 4 : 2;
            n_cmp++;
            if (bl_en[i] !== e_en || bl_len[i] != e_len) begin
                n_err++;
                $display("FAIL rr_burst%0d: rd_en=%b len=%0d, required %b len %0d", i, bl_en[i], bl_len[i], e_en, e_len);
            end
        end
        n_cmp++;
        if (n_pop - pop0 != 24 || pending_words() != 0) begin
            n_err++;
            $display("FAIL rr_total: popped=%0d pending=%0d, required 24/0", n_pop - pop0, pending_words());
        end
        $display("test_round_robin done");
    endtask

    task automatic test_two_words();
        logic [3:0] e_en;
        @(posedge clk_rd); #1;
        push(2, 8'hA1);
        push(2, 8'hA2);
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk_rd);
            e_en = (cyc == 1 || cyc == 2) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (fifo_rd_en !== e_en) begin
                n_err++;
                $display("FAIL two_rd_en: cyc=%0d rd_en=%b, required %b", cyc, fifo_rd_en, e_en);
            end
            if (cyc == 3 || cyc == 4) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_chan !== 2'd2 || m_data !== ((cyc == 3) ? 8'hA1 : 8'hA2)) begin
                    n_err++;
                    $display("FAIL two_word: cyc=%0d valid=%b chan=%0d data=%h, required 1/2/%h",
                             cyc, m_valid, m_chan, m_data, (cyc == 3) ? 8'hA1 : 8'hA2);
                end
            end
            if (cyc >= 5) begin
                n_cmp++;
                if (busy !== 1'b0 || m_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL two_idle: cyc=%0d busy=%b valid=%b, required 0/0", cyc, busy, m_valid);
                end
            end
        end
        $display("test_two_words done");
    endtask

    task automatic test_backpressure();
        bit ok;
        int rd_cnt = 0;
        int pop0;
        @(posedge clk_rd); #1;
        m_ready = 1'b0;
        pop0    = n_pop;
        for (int w = 0; w < 5; w++) push(1, 8'(8'h50 + w));
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk_rd);
            if (fifo_rd_en[1]) rd_cnt++;
            if (m_valid) begin
                n_cmp++;
                if (m_data !== 8'h50 || m_chan !== 2'd1) begin
                    n_err++;
                    $display("FAIL bp_stable: cyc=%0d data=%h chan=%0d, required 50/1", cyc, m_data, m_chan);
                end
            end
        end
        n_cmp++;
        if (rd_cnt != 2 || fifo_rd_en !== 4'b0 || m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_reads: reads=%0d rd_en=%b valid=%b, required 2/0000/1", rd_cnt, fifo_rd_en, m_valid);
        end
        @(posedge clk_rd); #1;
        m_ready = 1'b1;
        wait_drain(100, ok);
        n_cmp++;
        if (!ok || n_pop - pop0 != 5 || pending_words() != 0) begin
            n_err++;
            $display("FAIL bp_drain: ok=%0d popped=%0d pending=%0d, required 1/5/0", ok, n_pop - pop0, pending_words());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_random();
        bit ok;
        int pushed = 0;
        int pop0   = n_pop;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk_rd); #1;
            m_ready = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0 && (wr_ptr[c] - rd_ptr[c]) < 200) begin
                    push(c, 8'($urandom));
                    pushed++;
                end
            end
        end
        @(posedge clk_rd); #1;
        m_ready = 1'b1;
        wait_drain(5000, ok);
        n_cmp++;
        if (!ok || n_pop - pop0 != pushed || pending_words() != 0) begin
            n_err++;
            $display("FAIL random_drain: ok=%0d popped=%0d pending=%0d, required 1/%0d/0",
                     ok, n_pop - pop0, pending_words(), pushed);
        end
        $display("test_random done: %0d words", pushed);
    endtask

    task automatic test_reset_midburst();
        bit ok = 1'b0;
        @(posedge clk_rd); #1;
        m_ready = 1'b1;
        for (int w = 0; w < 4; w++) push(1, 8'(8'h70 + w));
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_rd);
            if (fifo_rd_en != 4'b0) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL mid_start: no read within 20 cycles, required a read"); end
        @(posedge clk_rd); #1;
        rd_reset = 1'b1;
        mon_en   = 1'b0;
        @(negedge clk_rd);
        n_cmp++;
        if (fifo_rd_en !== 4'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 8'h00 || m_chan !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset: rd_en=%b valid=%b busy=%b data=%h chan=%0d, required all 0",
                     fifo_rd_en, m_valid, busy, m_data, m_chan);
        end
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        out_cnt = 0;
        prev_en = 4'b0;
        cur_len = 0;
        @(posedge clk_rd); #1;
        rd_reset = 1'b0;
        mon_en   = 1'b1;
        push(3, 8'h3A);
        push(0, 8'h0A);
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk_rd);
            n_cmp++;
            if (fifo_rd_en !== ((cyc == 1) ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL mid_restart: cyc=%0d rd_en=%b, required %b", cyc, fifo_rd_en,
                         (cyc == 1) ? 4'b0001 : 4'b0000);
            end
        end
        wait_drain(100, ok);
        n_cmp++;
        if (!ok || pending_words() != 0) begin
            n_err++;
            $display("FAIL mid_drain: ok=%0d pending=%0d, required 1/0", ok, pending_words());
        end
        $display("test_reset_midburst done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_two_words();
        test_backpressure();
        test_random();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
